instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch/issue unit: owns the 64-bit PC, requests 32-bit instruction words from instruction memory, buffers returned words, and presents them in program order to the decode stage. The `control` decoder consumes the opcode bits. It is the producer end of the `instr[6:0]` interface that `control` receives. Decode/execute redirects it on taken branches.

## Interface
- `PC_W`, 64, PC and address width
- `INSTR_W`, 32, instruction word width
- `RESET_PC`, 64'h0, PC loaded at reset
- `DEPTH`, 4, instruction buffer entries and the maximum number of requests in flight; a power of 2, at least 2

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `en`  in  1  fetch enable; gates new requests only
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  PC_W  word address; bits [1:0] always 0
- `imem_rsp_valid`  in  1  response word valid; responses arrive in request order with arbitrary latency of at least 1 cycle
- `imem_rsp_data`  in  INSTR_W  instruction word
- `redirect_valid`  in  1  flush and restart at `redirect_pc`
- `redirect_pc`  in  PC_W  new fetch PC; bits [1:0] ignored and treated as 0
- `out_valid`  out  1  instruction available to decode
- `out_ready`  in  1  decode accepts
- `out_instr`  out  INSTR_W  buffer head word
- `out_pc`  out  PC_W  PC of buffer head
- `out_opcode`  out  7  `out_instr[6:0]`; connects to `control` `instr`
- `out_illegal`  out  1  opcode is not one of 0x33, 0x03, 0x23, 0x63, 0x13

## Operation
- State `pc`, in-flight counter `outst` (0..DEPTH), drop counter `drop` (0..`outst`), and a FIFO of DEPTH entries, each {pc, instr}.
- `credit_ok = (outst - drop + fifo_count) < DEPTH`.
- `imem_req_valid = en & credit_ok & ~redirect_valid`. It is combinational, and the request may be withdrawn. Only the req handshake commits a request.
- Req handshake: `outst` += 1 and `pc` += 4. The PC and address wrap modulo 2^PC_W.
- Response while `drop > 0`: the word is discarded, and both `drop` and `outst` decrement by 1.
- Response while `drop == 0`: the word is pushed into the FIFO with its PC and `outst` decrements by 1. A separate in-flight PC queue is not used; the FIFO PC tag comes from a `rsp_pc` counter that advances by 4 per kept response.
- FIFO overflow cannot occur because of `credit_ok`.
- Out handshake (`out_valid & out_ready`) pops the FIFO.
- Two-state FSM, IDLE and RUN:
  - IDLE→RUN when `en` = 1.
  - RUN→IDLE when `en` = 0; in-flight responses are still collected.
  - `redirect_valid` does not change the state.
- Redirect has priority over all other events in the same cycle:
  - `pc` and `rsp_pc` load `{redirect_pc[PC_W-1:2], 2'b00}`.
  - The FIFO is flushed.
  - `drop_next = outst - imem_rsp_valid`. Any response in the redirect cycle is discarded.
  - `out_valid` is forced to 0 in that cycle.
- Redirect while `drop > 0` (back-to-back redirect): the same formula applies, so all older responses are still dropped.
- `out_illegal` is combinational from `out_opcode`. It is meaningful only when `out_valid` = 1.

## Timing
- Reset values: `imem_req_valid` = 0, `out_valid` = 0, `out_instr` = 0, `out_pc` = RESET_PC, `out_illegal` = 0, `pc` = RESET_PC, `outst` = 0, `drop` = 0, FSM = IDLE.
- First request: the first cycle after `rst_n` deasserts with `en` = 1.
- Response accepted at edge N gives `out_valid` = 1 in cycle N+1, because the FIFO output is registered.
- Throughput: 1 instruction/cycle sustained when memory and decode are always ready.
- Redirect at edge R: the first request at `redirect_pc` is in cycle R+1. No instruction from the old path is visible at the output after R.
- Reset mid-operation clears all state immediately. Responses to pre-reset requests arriving after reset are not the block's concern; the memory is reset by the same `rst_n`.

## Structure
- Shared package `fetch_pkg`: opcode localparams OP_R = 7'h33, OP_LD = 7'h03, OP_ST = 7'h23, OP_BR = 7'h63, OP_I = 7'h13, and the fetch state enum {IDLE, RUN}. `control` uses the same opcode constants.
- One sub-module: `fetch_fifo`, a synchronous FIFO with parameters DEPTH and width PC_W+INSTR_W, ports push/pop/flush, and count.

## Test plan
- Reset, then `en` = 1, memory always ready, latency 1, words 0x00000033, 0x00000003, 0x00000023 → requests to 0x0, 0x4, 0x8. The outputs give `out_opcode` 0x33, 0x03, 0x23 with `out_pc` 0x0, 0x4, 0x8 on consecutive cycles and `out_illegal` = 0.
- `out_ready` held 0 → after 4 requests `imem_req_valid` = 0 and `fifo_count` = 4. Raising `out_ready` drains 4 in order, then fetching resumes at 0x10.
- Memory latency 3, and `redirect_valid` with pc 0x100 while 2 requests are outstanding → both stale responses are dropped. The first `out_pc` = 0x100, and no old-path instruction appears.
- Redirect with pc 0x203 in the same cycle as a response → the response is discarded, the next request address is 0x200, and `out_valid` = 0 that cycle.
- Word 0x00000047 → `out_opcode` = 0x47 and `out_illegal` = 1. Word 0x00000005 → `out_illegal` = 1.
- `rst_n` asserted mid-stream with a full FIFO → `out_valid` and `imem_req_valid` go to 0 immediately. After release the first request address is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: opcode encodings understood by control
// and the fetch FSM state type.
package fetch_pkg;

   localparam logic [6:0] OP_R  = 7'h33;
   localparam logic [6:0] OP_LD = 7'h03;
   localparam logic [6:0] OP_ST = 7'h23;
   localparam logic [6:0] OP_BR = 7'h63;
   localparam logic [6:0] OP_I  = 7'h13;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } fetch_state_e;

   function automatic logic is_legal_op(input logic [6:0] op);
      return (op == OP_R) || (op == OP_LD) || (op == OP_ST) ||
             (op == OP_BR) || (op == OP_I);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO for {pc, instr} entries; head read straight from the
// storage registers, flush empties it in one cycle.
module fetch_fifo #(
   parameter int             DEPTH     = 4,
   parameter int             W         = 96,
   parameter logic [W-1:0]   RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push_i,
   input  logic [W-1:0]               din_i,
   input  logic                       pop_i,
   input  logic                       flush_i,
   output logic [W-1:0]               dout_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0]   cnt_q;

   assign dout_o  = mem_q[rd_q];
   assign count_o = cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else if (flush_i) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= din_i;
            wr_q        <= wr_q + AW'(1);
         end
         if (pop_i) rd_q <= rd_q + AW'(1);
         cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word requests under a credit limit, tags
// in-order responses with their PC and queues them for decode.
module instr_fetch
   import fetch_pkg::*;
#(
   parameter int              PC_W     = 64,
   parameter int              INSTR_W  = 32,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [PC_W-1:0]    imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   output logic [6:0]         out_opcode,
   output logic               out_illegal
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e     state_q;
   logic [PC_W-1:0]  pc_q, pc_d, rsp_pc_q, rsp_pc_d, redir_pc;
   logic [CW-1:0]    outst_q, outst_d, drop_q, drop_d, fifo_cnt;
   logic [CW:0]      used_slots;
   logic             credit_ok, req_hs, push, pop;
   logic             unused_bits;

   assign redir_pc    = {redirect_pc[PC_W-1:2], 2'b00};
   assign unused_bits = ^redirect_pc[1:0];

   // Live requests still owed to the buffer plus words already buffered.
   assign used_slots = (CW+1)'(outst_q - drop_q) + (CW+1)'(fifo_cnt);
   assign credit_ok  = used_slots < (CW+1)'(DEPTH);

   // rst_n gate keeps the request low throughout reset, even with en high.
   assign imem_req_valid = rst_n & en & credit_ok & ~redirect_valid;
   assign imem_req_addr  = pc_q;
   assign req_hs         = imem_req_valid & imem_req_ready;

   assign out_valid   = (fifo_cnt != '0) & ~redirect_valid;
   assign pop         = out_valid & out_ready;
   assign out_opcode  = out_instr[6:0];
   assign out_illegal = out_valid & ~is_legal_op(out_opcode);

   always_comb begin
      pc_d     = pc_q;
      rsp_pc_d = rsp_pc_q;
      outst_d  = outst_q;
      drop_d   = drop_q;
      push     = 1'b0;
      if (redirect_valid) begin
         // Everything still in flight belongs to the old path.
         pc_d     = redir_pc;
         rsp_pc_d = redir_pc;
         outst_d  = outst_q - CW'(imem_rsp_valid);
         drop_d   = outst_q - CW'(imem_rsp_valid);
      end else begin
         if (req_hs) pc_d = pc_q + PC_W'(4);
         if (imem_rsp_valid) begin
            if (drop_q != '0) begin
               drop_d = drop_q - CW'(1);
            end else begin
               push     = 1'b1;
               rsp_pc_d = rsp_pc_q + PC_W'(4);
            end
         end
         outst_d = outst_q + CW'(req_hs) - CW'(imem_rsp_valid);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q     <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q  <= '0;
         drop_q   <= '0;
         state_q  <= IDLE;
      end else begin
         pc_q     <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q  <= outst_d;
         drop_q   <= drop_d;
         case (state_q)
            IDLE: if (en)  state_q <= RUN;
            RUN:  if (!en) state_q <= IDLE;
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH    (DEPTH),
      .W        (PC_W + INSTR_W),
      .RESET_VAL({RESET_PC, {INSTR_W{1'b0}}})
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push),
      .din_i  ({rsp_pc_q, imem_rsp_data}),
      .pop_i  (pop),
      .flush_i(redirect_valid),
      .dout_o ({out_pc, out_instr}),
      .count_o(fifo_cnt)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table for streaming and
// backpressure, hand sequences for redirect, illegal opcodes and reset.
module tb_instr_fetch;

   localparam int PC_W = 64, INSTR_W = 32, DEPTH = 4;

   logic               clk = 1'b0;
   logic               rst_n, en, imem_req_valid, imem_req_ready;
   logic [PC_W-1:0]    imem_req_addr, redirect_pc, out_pc;
   logic               imem_rsp_valid, redirect_valid, out_valid, out_ready;
   logic               out_illegal;
   logic [INSTR_W-1:0] imem_rsp_data, out_instr;
   logic [6:0]         out_opcode;

   instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .en(en),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_pc(out_pc), .out_opcode(out_opcode),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct { logic [63:0] addr; int due; } mreq_t;
   typedef struct {
      bit rst; bit en; bit ordy;
      bit exp_rv; logic [63:0] exp_addr;
      bit exp_ov; logic [63:0] exp_pc; logic [6:0] exp_op;
      int exp_cnt;
   } vec_t;

   mreq_t       mq[$];
   vec_t        tbl[16];
   int          cyc, lat, total, bad, got;
   logic [63:0] cpc[4];
   logic [6:0]  cop[4];
   logic        cill[4];

   function automatic logic [31:0] word_at(input logic [63:0] a);
      case (a)
         64'h0:   return 32'h00000033;
         64'h4:   return 32'h00000003;
         64'h8:   return 32'h00000023;
         64'h300: return 32'h00000047;
         64'h304: return 32'h00000005;
         default: return {a[24:0], 7'h13};
      endcase
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Drive the memory response for this cycle and let outputs settle.
   task automatic apply();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = word_at(mq[0].addr);
      end
      #1;
   endtask

   task automatic advance();
      logic        hs;
      logic [63:0] a;
      mreq_t       m;
      hs = imem_req_valid & imem_req_ready;
      a  = imem_req_addr;
      @(posedge clk);
      if (imem_rsp_valid) void'(mq.pop_front());
      if (hs) begin
         m.addr = a; m.due = cyc + lat;
         mq.push_back(m);
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0; en = 1'b0; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      mq.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic collect(input int n);
      got = 0;
      for (int k = 0; k < 30 && got < n; k++) begin
         apply();
         if (out_valid) begin
            cpc[got] = out_pc; cop[got] = out_opcode; cill[got] = out_illegal;
            got++;
         end
         advance();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      total = 0; bad = 0; lat = 1; cyc = 0;
      imem_req_ready = 1'b1;
      rst_n = 1'b0; en = 1'b1; out_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = '0;
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_pc", out_pc, 0);
      chk("rst_out_illegal", out_illegal, 0);

      // rst en ordy | rv addr | ov pc op | cnt
      tbl[0]  = '{1, 1, 1, 1, 64'h0,  0, 64'h0,  7'h00, -1};
      tbl[1]  = '{0, 1, 1, 1, 64'h4,  0, 64'h0,  7'h00, -1};
      tbl[2]  = '{0, 1, 1, 1, 64'h8,  1, 64'h0,  7'h33, -1};
      tbl[3]  = '{0, 1, 1, 1, 64'hC,  1, 64'h4,  7'h03, -1};
      tbl[4]  = '{0, 1, 1, 1, 64'h10, 1, 64'h8,  7'h23, -1};
      tbl[5]  = '{1, 1, 0, 1, 64'h0,  0, 64'h0,  7'h00, -1};
      tbl[6]  = '{0, 1, 0, 1, 64'h4,  0, 64'h0,  7'h00, -1};
      tbl[7]  = '{0, 1, 0, 1, 64'h8,  1, 64'h0,  7'h33, -1};
      tbl[8]  = '{0, 1, 0, 1, 64'hC,  1, 64'h0,  7'h33, -1};
      tbl[9]  = '{0, 1, 0, 0, 64'h0,  1, 64'h0,  7'h33, -1};
      tbl[10] = '{0, 1, 0, 0, 64'h0,  1, 64'h0,  7'h33,  4};
      tbl[11] = '{0, 1, 1, 0, 64'h0,  1, 64'h0,  7'h33, -1};
      tbl[12] = '{0, 1, 1, 1, 64'h10, 1, 64'h4,  7'h03, -1};
      tbl[13] = '{0, 1, 1, 1, 64'h14, 1, 64'h8,  7'h23, -1};
      tbl[14] = '{0, 1, 1, 1, 64'h18, 1, 64'hC,  7'h13, -1};
      tbl[15] = '{0, 1, 1, 1, 64'h1C, 1, 64'h10, 7'h13, -1};

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].rst) begin do_reset(); lat = 1; end
         en = tbl[i].en; out_ready = tbl[i].ordy;
         apply();
         chk($sformatf("v%0d_req_valid", i), imem_req_valid, tbl[i].exp_rv);
         if (tbl[i].exp_rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, tbl[i].exp_addr);
         chk($sformatf("v%0d_out_valid", i), out_valid, tbl[i].exp_ov);
         if (tbl[i].exp_ov) begin
            chk($sformatf("v%0d_out_pc", i), out_pc, tbl[i].exp_pc);
            chk($sformatf("v%0d_opcode", i), out_opcode, tbl[i].exp_op);
            chk($sformatf("v%0d_illegal", i), out_illegal, 0);
         end
         if (tbl[i].exp_cnt >= 0) chk($sformatf("v%0d_fifo_cnt", i), dut.fifo_cnt, tbl[i].exp_cnt);
         advance();
      end

      // Redirect with two stale requests in flight, latency 3.
      do_reset(); lat = 3; en = 1'b1; out_ready = 1'b1;
      apply(); chk("t3_req0", imem_req_addr, 64'h0); advance();
      apply(); chk("t3_req1", imem_req_addr, 64'h4); advance();
      redirect_valid = 1'b1; redirect_pc = 64'h100;
      apply();
      chk("t3_redir_req_valid", imem_req_valid, 0);
      chk("t3_redir_out_valid", out_valid, 0);
      advance(); redirect_valid = 1'b0;
      apply();
      chk("t3_first_req_valid", imem_req_valid, 1);
      chk("t3_first_req_addr", imem_req_addr, 64'h100);
      advance();
      collect(3);
      chk("t3_outputs_seen", got, 3);
      for (int k = 0; k < got; k++) chk($sformatf("t3_out_pc%0d", k), cpc[k], 64'h100 + 64'(4 * k));

      // Redirect coinciding with a response and a valid FIFO head.
      do_reset(); lat = 1; en = 1'b1; out_ready = 1'b1;
      apply(); advance();
      apply(); advance();
      redirect_valid = 1'b1; redirect_pc = 64'h203;
      apply();
      chk("t4_redir_out_valid", out_valid, 0);
      chk("t4_redir_req_valid", imem_req_valid, 0);
      advance(); redirect_valid = 1'b0;
      apply();
      chk("t4_next_req_addr", imem_req_addr, 64'h200);
      chk("t4_next_req_valid", imem_req_valid, 1);
      chk("t4_flushed_out_valid", out_valid, 0);
      advance();
      collect(1);
      chk("t4_outputs_seen", got, 1);
      if (got > 0) chk("t4_first_out_pc", cpc[0], 64'h200);

      // Illegal opcodes.
      do_reset(); lat = 1; en = 1'b1; out_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 64'h300;
      apply(); advance(); redirect_valid = 1'b0;
      collect(2);
      chk("t5_outputs_seen", got, 2);
      if (got == 2) begin
         chk("t5_pc0", cpc[0], 64'h300);
         chk("t5_op0", cop[0], 7'h47);
         chk("t5_ill0", cill[0], 1);
         chk("t5_op1", cop[1], 7'h05);
         chk("t5_ill1", cill[1], 1);
      end

      // Reset asserted with a full FIFO.
      do_reset(); lat = 1; en = 1'b1; out_ready = 1'b0;
      repeat (6) begin apply(); advance(); end
      apply();
      chk("t6_pre_out_valid", out_valid, 1);
      chk("t6_pre_fifo_cnt", dut.fifo_cnt, 4);
      rst_n = 1'b0; imem_rsp_valid = 1'b0; mq.delete();
      #1;
      chk("t6_rst_out_valid", out_valid, 0);
      chk("t6_rst_req_valid", imem_req_valid, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; cyc = 0;
      apply();
      chk("t6_post_req_valid", imem_req_valid, 1);
      chk("t6_post_req_addr", imem_req_addr, 64'h0);
      advance();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
